down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 147 ++++++++++++++
 tb/tb_down_timer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// down_timer
//
// Loadable down-counter with start/stop control and an expiry handshake.
// A LOAD captures DATA as the count (and, in auto-reload builds, as the
// reload period). START begins the countdown. Each DEC while running removes
// one from the count. Reaching zero raises a one-cycle TC pulse.
//
// Configuration:
//   DOWN_TIMER_RELOAD_EN undefined : one-shot. The terminal tick parks the
//                                    timer in EXPIRED (DONE=1) until ACK.
//   DOWN_TIMER_RELOAD_EN defined   : auto-reload. The terminal tick reloads
//                                    COUNT from PERIOD and keeps running.
//                                    DONE is constantly 0.
//
// Ports:
//   CLK      in   clock, rising edge active
//   RESET_N  in   asynchronous active-low reset
//   LOAD     in   load DATA into COUNT (and PERIOD); highest priority
//   DATA     in   [WIDTH] load value
//   START    in   start / resume countdown from IDLE (ignored when COUNT==0)
//   STOP     in   pause countdown (RUN -> IDLE, COUNT held)
//   DEC      in   decrement tick while running
//   ACK      in   acknowledge expiry (EXPIRED -> IDLE)
//   COUNT    out  [WIDTH] current count, registered
//   BUSY     out  high while in RUN
//   DONE     out  high while in EXPIRED
//   TC       out  terminal-count pulse, registered, one cycle wide
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DATA,
    input  logic             START,
    input  logic             STOP,
    input  logic             DEC,
    input  logic             ACK,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             TC
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

`ifdef DOWN_TIMER_RELOAD_EN
    // Reload value; only ever written by LOAD.
    logic [WIDTH-1:0] period;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            period <= '0;
        end else if (LOAD) begin
            period <= DATA;
        end
    end
`endif

    // State, count and TC registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            COUNT <= '0;
            TC    <= 1'b0;
        end else begin
            state <= state_nxt;
            COUNT <= count_nxt;
            TC    <= tc_nxt;
        end
    end

    // Next-state / next-count logic
    always_comb begin
        state_nxt = state;
        count_nxt = COUNT;
        tc_nxt    = 1'b0;

        if (LOAD) begin
            count_nxt = DATA;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // A zero count has nothing to count down, so START is ignored.
                    if (START && (COUNT != ZERO)) begin
                        state_nxt = RUN;
                    end
                end

                RUN: begin
                    if (STOP) begin
                        state_nxt = IDLE;
                    end else if (DEC) begin
                        if (COUNT > ONE) begin
                            count_nxt = COUNT - ONE;
                        end else if (COUNT == ONE) begin
                            // Terminal tick. COUNT==0 is never reached in RUN,
                            // so there is no path that could wrap below zero.
                            tc_nxt = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                            count_nxt = period;
`else
                            count_nxt = ZERO;
                            state_nxt = EXPIRED;
`endif
                        end
                    end
                end

                EXPIRED: begin
                    count_nxt = ZERO;
                    if (ACK) begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == RUN);
`ifdef DOWN_TIMER_RELOAD_EN
    assign DONE = 1'b0;
`else
    assign DONE = (state == EXPIRED);
`endif

endmodule

// File: tb/tb_down_timer.sv
`timescale 1ns/1ps
module tb_down_timer;

    localparam int WIDTH = 4;
    localparam time HALF = 50ns;

    logic             CLK;
    logic             RESET_N;
    logic             LOAD;
    logic [WIDTH-1:0] DATA;
    logic             START;
    logic             STOP;
    logic             DEC;
    logic             ACK;
    logic [WIDTH-1:0] COUNT;
    logic             BUSY;
    logic             DONE;
    logic             TC;

    int n_assert = 0;
    int n_fail   = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .LOAD    (LOAD),
        .DATA    (DATA),
        .START   (START),
        .STOP    (STOP),
        .DEC     (DEC),
        .ACK     (ACK),
        .COUNT   (COUNT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .TC      (TC)
    );

    initial CLK = 1'b0;
    always #(HALF) CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic b,
                             input logic d, input logic t);
        check({tag, ".count"}, 32'(COUNT), 32'(c));
        check({tag, ".busy"},  32'(BUSY),  32'(b));
        check({tag, ".done"},  32'(DONE),  32'(d));
        check({tag, ".tc"},    32'(TC),    32'(t));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] seq [6];

        RESET_N = 1'b0;
        LOAD = 1'b0; DATA = '0; START = 1'b0; STOP = 1'b0; DEC = 1'b0; ACK = 1'b0;

        // Reset state before the first edge
        #10;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        #10 RESET_N = 1'b1;
        tick();
        check_all("post_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // Pause / resume: LOAD 12, START, 3 DEC -> 9
        LOAD = 1'b1; DATA = 4'd12;
        tick();
        check_all("pr_load", 4'd12, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0; START = 1'b1;
        tick();
        check_all("pr_start", 4'd12, 1'b1, 1'b0, 1'b0);
        START = 1'b0; DEC = 1'b1;
        tick(); check("pr_dec1", 32'(COUNT), 32'd11);
        tick(); check("pr_dec2", 32'(COUNT), 32'd10);
        tick(); check_all("pr_dec3", 4'd9, 1'b1, 1'b0, 1'b0);
        // STOP beats DEC and START
        STOP = 1'b1; START = 1'b1;
        tick();
        check_all("pr_stop", 4'd9, 1'b0, 1'b0, 1'b0);
        // DEC in IDLE does nothing
        STOP = 1'b0; START = 1'b0;
        tick();
        check_all("pr_idle_dec", 4'd9, 1'b0, 1'b0, 1'b0);
        START = 1'b1; DEC = 1'b0;
        tick();
        check_all("pr_resume", 4'd9, 1'b1, 1'b0, 1'b0);
        START = 1'b0; DEC = 1'b1;
        tick();
        check_all("pr_resume_dec", 4'd8, 1'b1, 1'b0, 1'b0);
        DEC = 1'b0;
        tick();
        check_all("pr_hold", 4'd8, 1'b1, 1'b0, 1'b0);

        // Priority: count down to 3, then LOAD 7 with DEC=1
        DEC = 1'b1;
        repeat (5) tick();
        check_all("pri_at3", 4'd3, 1'b1, 1'b0, 1'b0);
        LOAD = 1'b1; DATA = 4'd7;
        tick();
        check_all("pri_load", 4'd7, 1'b0, 1'b0, 1'b0);
        DATA = 4'd0; DEC = 1'b0;
        tick();
        check_all("pri_load0", 4'd0, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b0; START = 1'b1;
        tick();
        check_all("pri_start0", 4'd0, 1'b0, 1'b0, 1'b0);
        START = 1'b0;

        // Mid-run reset at COUNT=2
        LOAD = 1'b1; DATA = 4'd4;
        tick();
        LOAD = 1'b0; START = 1'b1;
        tick();
        START = 1'b0; DEC = 1'b1;
        tick(); tick();
        check_all("mr_at2", 4'd2, 1'b1, 1'b0, 1'b0);
        #20 RESET_N = 1'b0;
        #1;
        check_all("mr_async", 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("mr_held", 4'd0, 1'b0, 1'b0, 1'b0);
        #20 RESET_N = 1'b1;
        tick();
        check_all("mr_release", 4'd0, 1'b0, 1'b0, 1'b0);
        DEC = 1'b0;

`ifndef DOWN_TIMER_RELOAD_EN
        // One-shot: LOAD 5, START, DEC -> 4,3,2,1,0 with TC at 0
        LOAD = 1'b1; DATA = 4'd5;
        tick();
        LOAD = 1'b0; START = 1'b1;
        tick();
        check_all("os_start", 4'd5, 1'b1, 1'b0, 1'b0);
        START = 1'b0; DEC = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_all("os_dec", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_all("os_expire", 4'd0, 1'b0, 1'b1, 1'b1);
        START = 1'b1;
        tick();
        check_all("os_hold1", 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("os_hold2", 4'd0, 1'b0, 1'b1, 1'b0);
        // ACK with coincident START returns to IDLE, not RUN
        ACK = 1'b1;
        tick();
        check_all("os_ack", 4'd0, 1'b0, 1'b0, 1'b0);
        ACK = 1'b0; START = 1'b0;
        tick();
        check_all("os_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        DEC = 1'b0;
`else
        // Auto-reload: LOAD 3 -> 2,1,3,2,1,3 with TC on each 1->3
        seq[0] = 4'd2; seq[1] = 4'd1; seq[2] = 4'd3;
        seq[3] = 4'd2; seq[4] = 4'd1; seq[5] = 4'd3;
        LOAD = 1'b1; DATA = 4'd3;
        tick();
        LOAD = 1'b0; START = 1'b1;
        tick();
        check_all("rl_start", 4'd3, 1'b1, 1'b0, 1'b0);
        START = 1'b0; DEC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("rl_seq", seq[i], 1'b1, 1'b0, (seq[i] == 4'd3));
        end
        DEC = 1'b0;
        tick();
        check_all("rl_hold", 4'd3, 1'b1, 1'b0, 1'b0);
        // PERIOD==1: TC on every DEC cycle
        LOAD = 1'b1; DATA = 4'd1;
        tick();
        LOAD = 1'b0; START = 1'b1;
        tick();
        START = 1'b0; DEC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("rl_p1", 4'd1, 1'b1, 1'b0, 1'b1);
        end
        DEC = 1'b0;
        tick();
        check_all("rl_p1_hold", 4'd1, 1'b1, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200us;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
